// File: rtl/timer_digit_loader.sv
// rtl/timer_digit_loader.sv - keypad digit buffer and parallel-load driver for the mm:ss countdown chain
module timer_digit_loader #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              clearn,
   input  logic [3:0]        key_in,
   input  logic              key_valid,
   input  logic              start,
   input  logic              cancel,
   output logic [4*NDIG-1:0] data_out,
   output logic              load_n,
   output logic [2:0]        digit_count,
   output logic              armed,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_LOAD,
      S_ARMED
   } state_t;

   state_t            r_state;
   logic [4*NDIG-1:0] r_data;
   logic [2:0]        r_count;
   logic              r_load_n;
   logic              r_armed;
   logic              r_err;
   logic              r_key_prev;
   logic              r_key_seen_low;

   state_t            w_state;
   logic [4*NDIG-1:0] w_data;
   logic [2:0]        w_count;
   logic              w_load_n;
   logic              w_armed;
   logic              w_err;
   logic              w_key_event;
   logic              w_key_ok;
   logic              w_room;
   logic              w_start_ok;

   // A key held across reset release must be let go before it counts.
   assign w_key_event = key_valid & ~r_key_prev & r_key_seen_low;
   assign w_key_ok    = (key_in <= 4'd9);
   assign w_room      = (r_count < 3'(NDIG));
   assign w_start_ok  = (r_count != 3'd0) && (r_data[7:4] <= 4'd5);

   always_comb begin
      w_state  = r_state;
      w_data   = r_data;
      w_count  = r_count;
      w_load_n = 1'b1;
      w_armed  = r_armed;
      w_err    = 1'b0;
      if (cancel) begin
         w_state = S_IDLE;
         w_data  = '0;
         w_count = 3'd0;
         w_armed = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_err = 1'b1;
               end else if (w_key_event) begin
                  if (w_key_ok) begin
                     w_data  = {r_data[4*NDIG-5:0], key_in};
                     w_count = r_count + 3'd1;
                     w_state = S_ENTRY;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            S_ENTRY: begin
               if (start) begin
                  if (w_start_ok) begin
                     w_state  = S_LOAD;
                     w_load_n = 1'b0;
                  end else begin
                     w_err = 1'b1;
                  end
               end else if (w_key_event) begin
                  if (w_key_ok && w_room) begin
                     w_data  = {r_data[4*NDIG-5:0], key_in};
                     w_count = r_count + 3'd1;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               w_state = S_ARMED;
               w_armed = 1'b1;
            end
            S_ARMED: begin
               if (start) begin
                  if (w_start_ok) begin
                     w_state  = S_LOAD;
                     w_load_n = 1'b0;
                  end else begin
                     w_err = 1'b1;
                  end
               end else if (w_key_event) begin
                  // First edit after a load starts a fresh entry.
                  if (w_key_ok) begin
                     w_data  = {{(4*NDIG-4){1'b0}}, key_in};
                     w_count = 3'd1;
                     w_armed = 1'b0;
                     w_state = S_ENTRY;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            default: begin
               w_state = S_IDLE;
               w_data  = '0;
               w_count = 3'd0;
               w_armed = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         r_state        <= S_IDLE;
         r_data         <= '0;
         r_count        <= 3'd0;
         r_load_n       <= 1'b1;
         r_armed        <= 1'b0;
         r_err          <= 1'b0;
         r_key_prev     <= 1'b0;
         r_key_seen_low <= 1'b0;
      end else begin
         r_state        <= w_state;
         r_data         <= w_data;
         r_count        <= w_count;
         r_load_n       <= w_load_n;
         r_armed        <= w_armed;
         r_err          <= w_err;
         r_key_prev     <= key_valid;
         r_key_seen_low <= r_key_seen_low | ~key_valid;
      end
   end

   assign data_out    = r_data;
   assign load_n      = r_load_n;
   assign digit_count = r_count;
   assign armed       = r_armed;
   assign err         = r_err;

endmodule

// File: tb/tb_timer_digit_loader.sv
// tb/tb_timer_digit_loader.sv - directed scenario bench for timer_digit_loader
module tb_timer_digit_loader;

   logic        clk = 1'b0;
   logic        clearn;
   logic [3:0]  key_in;
   logic        key_valid;
   logic        start;
   logic        cancel;
   logic [15:0] data_out;
   logic        load_n;
   logic [2:0]  digit_count;
   logic        armed;
   logic        err;

   int errors = 0;
   int checks = 0;
   int mon_err = 0;
   int mon_load = 0;
   int mon_chg = 0;
   int err_double = 0;
   logic        prev_err = 1'b0;
   logic [15:0] prev_data = 16'h0;

   timer_digit_loader #(.NDIG(4)) dut (
      .clk         (clk),
      .clearn      (clearn),
      .key_in      (key_in),
      .key_valid   (key_valid),
      .start       (start),
      .cancel      (cancel),
      .data_out    (data_out),
      .load_n      (load_n),
      .digit_count (digit_count),
      .armed       (armed),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (err === 1'b1) mon_err++;
      if (load_n === 1'b0) mon_load++;
      if (data_out !== prev_data) mon_chg++;
      if (err === 1'b1 && prev_err === 1'b1) err_double++;
      prev_err  = err;
      prev_data = data_out;
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_mon;
      mon_err  = 0;
      mon_load = 0;
      mon_chg  = 0;
   endtask

   task automatic press(input logic [3:0] k, input int hold);
      key_in    = k;
      key_valid = 1'b1;
      repeat (hold) tick();
      key_valid = 1'b0;
      tick();
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_cancel;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   task automatic test_reset;
      clearn    = 1'b0;
      key_in    = 4'h0;
      key_valid = 1'b0;
      start     = 1'b0;
      cancel    = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (data_out !== 16'h0000) begin $display("FAIL reset_data: got %h expected 0000", data_out); errors++; end
      checks++;
      if ({load_n, armed, err, digit_count} !== 6'b100000) begin
         $display("FAIL reset_ctrl: got load_n=%b armed=%b err=%b cnt=%0d expected 1 0 0 0", load_n, armed, err, digit_count);
         errors++;
      end
      clearn = 1'b1;
      tick();
   endtask

   task automatic test_entry;
      clr_mon();
      press(4'd1, 3);
      press(4'd2, 3);
      press(4'd3, 3);
      press(4'd0, 3);
      checks++;
      if (data_out !== 16'h1230) begin $display("FAIL entry_data: got %h expected 1230", data_out); errors++; end
      checks++;
      if (digit_count !== 3'd4) begin $display("FAIL entry_count: got %0d expected 4", digit_count); errors++; end
      checks++;
      if (mon_chg !== 4) begin $display("FAIL entry_shifts: got %0d expected 4", mon_chg); errors++; end
      checks++;
      if (mon_err !== 0) begin $display("FAIL entry_err: got %0d err cycles expected 0", mon_err); errors++; end
   endtask

   task automatic test_overflow;
      clr_mon();
      press(4'd7, 2);
      checks++;
      if (mon_err !== 1 || data_out !== 16'h1230 || digit_count !== 3'd4) begin
         $display("FAIL overflow: got err_cycles=%0d data=%h cnt=%0d expected 1 1230 4", mon_err, data_out, digit_count);
         errors++;
      end
      pulse_cancel();
      clr_mon();
      press(4'hB, 2);
      checks++;
      if (mon_err !== 1 || digit_count !== 3'd0 || data_out !== 16'h0000) begin
         $display("FAIL bad_key: got err_cycles=%0d cnt=%0d data=%h expected 1 0 0000", mon_err, digit_count, data_out);
         errors++;
      end
   endtask

   task automatic test_load;
      pulse_cancel();
      press(4'd4, 1);
      press(4'd5, 1);
      clr_mon();
      pulse_start();
      checks++;
      if (load_n !== 1'b0 || data_out !== 16'h0045) begin
         $display("FAIL load1_pulse: got load_n=%b data=%h expected 0 0045", load_n, data_out);
         errors++;
      end
      tick();
      checks++;
      if (load_n !== 1'b1 || armed !== 1'b1) begin
         $display("FAIL load1_armed: got load_n=%b armed=%b expected 1 1", load_n, armed);
         errors++;
      end
      pulse_start();
      checks++;
      if (load_n !== 1'b0 || data_out !== 16'h0045) begin
         $display("FAIL load2_pulse: got load_n=%b data=%h expected 0 0045", load_n, data_out);
         errors++;
      end
      tick();
      checks++;
      if (mon_load !== 2 || armed !== 1'b1) begin
         $display("FAIL load_count: got pulses=%0d armed=%b expected 2 1", mon_load, armed);
         errors++;
      end
   endtask

   task automatic test_reject;
      pulse_cancel();
      press(4'd7, 1);
      press(4'd0, 1);
      clr_mon();
      pulse_start();
      checks++;
      if (err !== 1'b1 || load_n !== 1'b1 || data_out !== 16'h0070) begin
         $display("FAIL reject_tens: got err=%b load_n=%b data=%h expected 1 1 0070", err, load_n, data_out);
         errors++;
      end
      tick();
      pulse_cancel();
      pulse_start();
      checks++;
      if (err !== 1'b1 || load_n !== 1'b1 || digit_count !== 3'd0) begin
         $display("FAIL reject_idle: got err=%b load_n=%b cnt=%0d expected 1 1 0", err, load_n, digit_count);
         errors++;
      end
      tick();
      checks++;
      if (mon_load !== 0) begin $display("FAIL reject_pulses: got %0d expected 0", mon_load); errors++; end
   endtask

   task automatic test_armed_edit;
      pulse_cancel();
      press(4'd4, 1);
      press(4'd5, 1);
      pulse_start();
      tick();
      press(4'd9, 2);
      checks++;
      if (data_out !== 16'h0009 || digit_count !== 3'd1 || armed !== 1'b0) begin
         $display("FAIL armed_edit: got data=%h cnt=%0d armed=%b expected 0009 1 0", data_out, digit_count, armed);
         errors++;
      end
      clr_mon();
      start  = 1'b1;
      cancel = 1'b1;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      tick();
      checks++;
      if (data_out !== 16'h0000 || digit_count !== 3'd0 || mon_load !== 0 || mon_err !== 0) begin
         $display("FAIL cancel_start: got data=%h cnt=%0d pulses=%0d err_cycles=%0d expected 0000 0 0 0",
                  data_out, digit_count, mon_load, mon_err);
         errors++;
      end
   endtask

   task automatic test_async_reset;
      press(4'd4, 1);
      press(4'd5, 1);
      pulse_start();
      checks++;
      if (load_n !== 1'b0) begin $display("FAIL async_pre: got load_n=%b expected 0", load_n); errors++; end
      #2 clearn = 1'b0;
      #1;
      checks++;
      if (load_n !== 1'b1 || data_out !== 16'h0000) begin
         $display("FAIL async_clear: got load_n=%b data=%h expected 1 0000", load_n, data_out);
         errors++;
      end
      key_in    = 4'd3;
      key_valid = 1'b1;
      @(negedge clk);
      clearn = 1'b1;
      tick();
      tick();
      checks++;
      if (data_out !== 16'h0000 || digit_count !== 3'd0 || err !== 1'b0) begin
         $display("FAIL held_key: got data=%h cnt=%0d err=%b expected 0000 0 0", data_out, digit_count, err);
         errors++;
      end
      key_valid = 1'b0;
      tick();
      key_valid = 1'b1;
      tick();
      checks++;
      if (data_out !== 16'h0003 || digit_count !== 3'd1) begin
         $display("FAIL repress: got data=%h cnt=%0d expected 0003 1", data_out, digit_count);
         errors++;
      end
      key_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_entry();
      test_overflow();
      test_load();
      test_reject();
      test_armed_edit();
      test_async_reset();
      checks++;
      if (err_double !== 0) begin $display("FAIL err_width: got %0d double-cycle err expected 0", err_double); errors++; end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
